// File: rtl/cache_controller.sv
// Data-cache controller: zero-wait read hits, two-word line refill on a read miss,
// write-through / no-write-allocate stores. Optional CACHE_STATS_EN adds hit/miss counters.
module cache_controller #(
   parameter int unsigned BASE_ADDR = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   input  logic        MEM_R_EN,
   input  logic        MEM_W_EN,
   output logic [31:0] rdata,
   output logic        ready,
   output logic [18:0] cache_address,
   output logic [31:0] cache_wdata,
   output logic        cache_w_en,
   output logic        invalidate,
   output logic        change_LRU,
   input  logic        hit,
   input  logic [31:0] cache_rdata,
   output logic [31:0] sram_address,
   output logic [31:0] sram_wdata,
   output logic        sram_r_en,
   output logic        sram_w_en,
   input  logic [63:0] sram_rdata,
   input  logic        sram_ready
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam logic [18:0] BASE_LO = 19'(BASE_ADDR);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      READ_WAIT  = 3'd1,
      FILL_LO    = 3'd2,
      FILL_HI    = 3'd3,
      DONE_R     = 3'd4,
      WRITE_WAIT = 3'd5
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [63:0] line_buf;
   logic        store_req;
   logic        load_req;
   logic [18:0] offset;

   // Only the low 19 bits of (address - BASE_ADDR) reach the cache, so subtract narrow.
   assign offset    = address[18:0] - BASE_LO;
   assign store_req = MEM_W_EN;
   assign load_req  = MEM_R_EN & ~MEM_W_EN;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Line buffer captures the SRAM line when the read completes.
   always_ff @(posedge clk) begin
      if (rst)                                 line_buf <= '0;
      else if (state == READ_WAIT && sram_ready) line_buf <= sram_rdata;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (store_req)             state_nxt = WRITE_WAIT;
            else if (load_req && !hit) state_nxt = READ_WAIT;
         end
         READ_WAIT:  if (sram_ready) state_nxt = FILL_LO;
         FILL_LO:    state_nxt = FILL_HI;
         FILL_HI:    state_nxt = DONE_R;
         DONE_R:     state_nxt = IDLE;
         WRITE_WAIT: if (sram_ready) state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready         = 1'b0;
      rdata         = '0;
      cache_address = offset;
      cache_wdata   = '0;
      cache_w_en    = 1'b0;
      invalidate    = 1'b0;
      change_LRU    = 1'b0;
      sram_address  = {address[31:3], 3'b000};
      sram_wdata    = wdata;
      sram_r_en     = 1'b0;
      sram_w_en     = 1'b0;
      case (state)
         IDLE: begin
            if (store_req) begin
               invalidate   = hit;
               sram_w_en    = 1'b1;
               sram_address = address;
            end else if (load_req) begin
               if (hit) begin
                  ready = 1'b1;
                  rdata = cache_rdata;
               end else begin
                  sram_r_en = 1'b1;
               end
            end else begin
               ready = 1'b1;
            end
         end
         READ_WAIT: sram_r_en = 1'b1;
         FILL_LO: begin
            cache_w_en    = 1'b1;
            cache_address = {offset[18:3], 1'b0, offset[1:0]};
            cache_wdata   = line_buf[31:0];
         end
         FILL_HI: begin
            cache_w_en    = 1'b1;
            cache_address = {offset[18:3], 1'b1, offset[1:0]};
            cache_wdata   = line_buf[63:32];
            change_LRU    = 1'b1;
         end
         DONE_R: begin
            ready = 1'b1;
            rdata = address[2] ? line_buf[63:32] : line_buf[31:0];
         end
         WRITE_WAIT: begin
            sram_w_en    = 1'b1;
            sram_address = address;
            ready        = sram_ready;
         end
         default: ;
      endcase
   end

`ifdef CACHE_STATS_EN
   // Saturating hit / miss counters, sampled only in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (state == IDLE && load_req) begin
         if (hit && hit_count != '1)    hit_count  <= hit_count + 32'd1;
         if (!hit && miss_count != '1)  miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Sits between the MEM stage and the SRAM controller. Drives the 2-way, 64-set, 2-word-line data cache (cache_w_en, invalidate, change_LRU).
- Serves read hits in zero wait cycles. Refills a full 64-bit line from SRAM on a read miss, written as two word writes.
- Write-through, no-write-allocate: every store goes to SRAM, and a matching cache line is invalidated.
- Stalls the pipeline through `ready` while it is busy.

Parameters:
- BASE_ADDR, 1024, first data-memory byte address; it is subtracted before cache indexing.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- address  in  32  MEM-stage byte address
- wdata  in  32  store data
- MEM_R_EN  in  1  load request
- MEM_W_EN  in  1  store request
- rdata  out  32  load result
- ready  out  1  1 means the request completes this cycle; 0 means freeze the pipeline
- cache_address  out  19  (address - BASE_ADDR)[18:0]; bit2 selects the word, in FILL states bit2 is forced
- cache_wdata  out  32  word written into the cache
- cache_w_en  out  1  cache word write
- invalidate  out  1  invalidate the hitting way
- change_LRU  out  1  toggle the LRU bit with this write
- hit  in  1  cache hit
- cache_rdata  in  32  cache read word
- sram_address  out  32  to the SRAM controller; {address[31:3],3'b0} for reads, address for writes
- sram_wdata  out  32  store data
- sram_r_en  out  1  64-bit line read request
- sram_w_en  out  1  32-bit write request
- sram_rdata  in  64  line data: [31:0] is the word at bit2=0, [63:32] is the word at bit2=1
- sram_ready  in  1  one-cycle pulse when the SRAM operation is complete

Behaviour:
- Reset (rst=1 at a rising edge):
  - state goes to IDLE and the line buffer clears to 0.
  - All cache_* strobes, sram_r_en, sram_w_en and rdata are 0.
  - ready follows the IDLE rules below.
  - Reset mid-operation abandons the operation; no cache write follows.
- Requests stay stable while ready=0.
- MEM_R_EN and MEM_W_EN both high is treated as a store.
- States: IDLE, READ_WAIT, FILL_LO, FILL_HI, DONE_R, WRITE_WAIT.
- IDLE, no request: ready=1, all strobes 0.
- IDLE, load hit: ready=1 and rdata=cache_rdata in the same cycle. Stay in IDLE.
- IDLE, load miss: ready=0, sram_r_en=1, go to READ_WAIT.
- READ_WAIT:
  - sram_r_en=1, ready=0.
  - On sram_ready, latch sram_rdata into the line buffer and go to FILL_LO.
- FILL_LO: cache_w_en=1, cache_address bit2=0, cache_wdata=buf[31:0], change_LRU=0. Go to FILL_HI.
- FILL_HI: cache_w_en=1, bit2=1, cache_wdata=buf[63:32], change_LRU=1. Go to DONE_R.
- DONE_R:
  - ready=1; rdata=buf[63:32] if address[2]=1, else buf[31:0].
  - Go to IDLE.
  - Total load-miss latency is the SRAM latency + 3 cycles.
- IDLE, store:
  - invalidate=hit in this cycle; sram_w_en=1; ready=0.
  - Go to WRITE_WAIT.
- WRITE_WAIT:
  - sram_w_en=1, ready=0.
  - On sram_ready: ready=1 that cycle, go to IDLE.
- invalidate is only ever asserted in the IDLE store cycle. cache_w_en is asserted only in FILL_LO/FILL_HI. They are never high together.
- sram_r_en and sram_w_en are never high together. Both drop in the cycle after sram_ready.
- A sram_ready arriving in any state other than READ_WAIT/WRITE_WAIT is ignored.
- Address arithmetic is 32-bit unsigned and wraps; bits above 18 are dropped for cache_address.

Optional Feature:
- Macro CACHE_STATS_EN.
- When defined: extra output ports hit_count[31:0] and miss_count[31:0], both synchronously reset to 0.
  - hit_count increments on each IDLE load-hit cycle.
  - miss_count increments on each IDLE→READ_WAIT transition.
  - Both saturate at 0xFFFFFFFF.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- rst=1 for 2 cycles, no request → ready=1; cache_w_en, invalidate, sram_r_en, sram_w_en all 0; rdata=0.
- Load address=0x400, hit=1, cache_rdata=0xDEADBEEF → ready=1 and rdata=0xDEADBEEF in the same cycle; no SRAM request.
- Load address=0x40C, hit=0; SRAM returns 0x11112222_33334444 after 5 cycles →
  - sram_address=0x408;
  - FILL_LO writes 0x33334444 with cache_address=0x008;
  - FILL_HI writes 0x11112222 with cache_address=0x00C and change_LRU=1;
  - DONE_R gives ready=1, rdata=0x11112222.
- Store address=0x410, wdata=0xCAFE0001, hit=1, sram_ready after 4 cycles → invalidate=1 for 1 cycle only; sram_w_en held 4 cycles; ready=1 on the sram_ready cycle; no cache_w_en.
- rst asserted during READ_WAIT, then a sram_ready pulse → IDLE; no cache_w_en; ready=1.
- CACHE_STATS_EN defined, sequence of 3 hits and 2 misses → hit_count=3, miss_count=2.
